// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: register count,
// default widths, round-robin priority encoding and pending-counter bound.
package regfile_wb_arbiter_pkg;

  localparam int unsigned NREG   = 32;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned AW_DEF = 5;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  // Worst case per register: both queues full of it plus one on the write port.
  function automatic int unsigned cnt_max(input int unsigned depth);
    return 2 * depth + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two valid/ready sources, the registered register-file write
// port, and the per-register busy scoreboard.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);

  logic                                    A_Valid;
  logic                                    A_Ready;
  logic [AW-1:0]                           A_Wr;
  logic [DW-1:0]                           A_D;
  logic                                    B_Valid;
  logic                                    B_Ready;
  logic [AW-1:0]                           B_Wr;
  logic [DW-1:0]                           B_D;
  logic [AW-1:0]                           Wr;
  logic [DW-1:0]                           D;
  logic                                    We;
  logic [regfile_wb_arbiter_pkg::NREG-1:0] Busy;
  logic                                    Idle;

  modport master (
    output A_Valid, A_Wr, A_D, B_Valid, B_Wr, B_D,
    input  A_Ready, B_Ready, Wr, D, We, Busy, Idle
  );

  modport slave (
    input  A_Valid, A_Wr, A_D, B_Valid, B_Wr, B_D,
    output A_Ready, B_Ready, Wr, D, We, Busy, Idle
  );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Synchronous FIFO holding queued {register, data} writes for one writeback source.
module regfile_wb_arbiter_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam logic [PW:0] ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wptr;
  logic [PW:0]  rptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign dout  = mem[rptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) begin
        wptr <= wptr + ONE;
      end
      if (pop && !empty) begin
        rptr <= rptr + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wptr[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between two queued writeback sources with
// round-robin arbitration, and tracks in-flight writes per register for hazard stalls.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned CW    = 3
) (
  input logic                 Clk,
  input logic                 Clr,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned   EW      = AW + DW;
  localparam logic [CW-1:0] CNT_MAX = CW'(cnt_max(DEPTH));

  logic          a_full, a_empty, a_push;
  logic          b_full, b_empty, b_push;
  logic [EW-1:0] a_dout, b_dout;
  logic          pop_a, pop_b;
  prio_e         prio;

  logic          we_q;
  logic [AW-1:0] wr_q;
  logic [DW-1:0] d_q;

  logic [CW-1:0]   cnt     [NREG];
  logic [CW-1:0]   cnt_nxt [NREG];
  logic [NREG-1:0] busy;

  // Writes to r0 complete the handshake but never enter a queue.
  assign a_push = bus.A_Valid & ~a_full & (bus.A_Wr != '0);
  assign b_push = bus.B_Valid & ~b_full & (bus.B_Wr != '0);

  assign bus.A_Ready = ~a_full;
  assign bus.B_Ready = ~b_full;
  assign bus.We      = we_q;
  assign bus.Wr      = wr_q;
  assign bus.D       = d_q;
  assign bus.Busy    = busy;
  assign bus.Idle    = a_empty & b_empty & ~we_q;

  regfile_wb_arbiter_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo_a (
    .clk   (Clk),
    .rst   (Clr),
    .push  (a_push),
    .din   ({bus.A_Wr, bus.A_D}),
    .pop   (pop_a),
    .dout  (a_dout),
    .full  (a_full),
    .empty (a_empty)
  );

  regfile_wb_arbiter_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo_b (
    .clk   (Clk),
    .rst   (Clr),
    .push  (b_push),
    .din   ({bus.B_Wr, bus.B_D}),
    .pop   (pop_b),
    .dout  (b_dout),
    .full  (b_full),
    .empty (b_empty)
  );

  always_comb begin
    pop_a = ~a_empty & (b_empty | (prio == PRIO_A));
    pop_b = ~b_empty & (a_empty | (prio == PRIO_B));
  end

  // The source just granted always drops to lowest priority.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      we_q <= 1'b0;
      wr_q <= '0;
      d_q  <= '0;
      prio <= PRIO_A;
    end else begin
      we_q <= pop_a | pop_b;
      if (pop_a) begin
        {wr_q, d_q} <= a_dout;
        prio        <= PRIO_B;
      end else if (pop_b) begin
        {wr_q, d_q} <= b_dout;
        prio        <= PRIO_A;
      end
    end
  end

  // Accepts increment, the end of a write-port cycle decrements; both may hit one register.
  always_comb begin
    cnt_nxt = '{default: '0};
    busy    = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_nxt[r] = cnt[r]
                 + CW'(a_push && (bus.A_Wr == AW'(r)))
                 + CW'(b_push && (bus.B_Wr == AW'(r)))
                 - CW'(we_q && (wr_q == AW'(r)));
      busy[r]    = (cnt[r] != '0);
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        assert (cnt_nxt[r] <= CNT_MAX)
          else $error("pending counter out of range for register %0d", r);
        cnt[r] <= cnt_nxt[r];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: accepted writes are queued per source
// and matched against the write port; busy, ready and idle follow a reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic clr = 1'b1;

  regfile_wb_arbiter_if #(.DW(32), .AW(5)) bus ();

  regfile_wb_arbiter #(
    .DEPTH (DEPTH),
    .DW    (32),
    .AW    (5),
    .CW    (3)
  ) dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cnt_m [32];
  ent_t sba [$];
  ent_t sbb [$];
  bit   grants [$];
  logic a_acc = 1'b0;
  logic b_acc = 1'b0;

  task automatic clear_model();
    sba.delete();
    sbb.delete();
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
  endtask

  task automatic idle_inputs();
    bus.A_Valid = 1'b0; bus.A_Wr = '0; bus.A_D = '0;
    bus.B_Valid = 1'b0; bus.B_Wr = '0; bus.B_D = '0;
  endtask

  // One clock: record handshakes, advance the model, then check all outputs.
  task automatic tick();
    logic        dv;
    logic [4:0]  dr;
    ent_t        got;
    logic [31:0] be;
    logic        ie;
    a_acc = bus.A_Valid && bus.A_Ready;
    b_acc = bus.B_Valid && bus.B_Ready;
    dv = bus.We;
    dr = bus.Wr;
    if (a_acc && bus.A_Wr != 5'd0) begin
      sba.push_back({bus.A_Wr, bus.A_D});
      cnt_m[bus.A_Wr]++;
    end
    if (b_acc && bus.B_Wr != 5'd0) begin
      sbb.push_back({bus.B_Wr, bus.B_D});
      cnt_m[bus.B_Wr]++;
    end
    if (dv) cnt_m[dr]--;
    @(posedge clk); #1;
    if (bus.We) begin
      got = {bus.Wr, bus.D};
      total++;
      if (sba.size() > 0 && got === sba[0]) begin
        void'(sba.pop_front());
        grants.push_back(1'b0);
      end else if (sbb.size() > 0 && got === sbb[0]) begin
        void'(sbb.pop_front());
        grants.push_back(1'b1);
      end else begin
        bad++;
        $display("FAIL wb_order: got wr=%0d d=%h, want head of A (%0d) or B (%0d) queue",
                 bus.Wr, bus.D, sba.size(), sbb.size());
      end
    end
    be = '0;
    for (int r = 0; r < 32; r++) be[r] = (cnt_m[r] != 0);
    total++;
    if (bus.Busy !== be) begin
      bad++;
      $display("FAIL busy: got %h want %h", bus.Busy, be);
    end
    total++;
    if (bus.A_Ready !== (sba.size() < DEPTH)) begin
      bad++;
      $display("FAIL a_ready: got %b want %b", bus.A_Ready, sba.size() < DEPTH);
    end
    total++;
    if (bus.B_Ready !== (sbb.size() < DEPTH)) begin
      bad++;
      $display("FAIL b_ready: got %b want %b", bus.B_Ready, sbb.size() < DEPTH);
    end
    ie = (sba.size() == 0) && (sbb.size() == 0) && !bus.We;
    total++;
    if (bus.Idle !== ie) begin
      bad++;
      $display("FAIL idle: got %b want %b", bus.Idle, ie);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sba.size() == 0 && sbb.size() == 0 && !bus.We) break;
      tick();
    end
    total++;
    if (sba.size() != 0 || sbb.size() != 0 || bus.We !== 1'b0) begin
      bad++;
      $display("FAIL drain_timeout: got a=%0d b=%0d we=%b want 0 0 0", sba.size(), sbb.size(), bus.We);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    int ia;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.We, bus.Wr, bus.D, bus.Busy, bus.Idle} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got we=%b wr=%0d d=%h busy=%h idle=%b want 0 0 0 0 1",
               bus.We, bus.Wr, bus.D, bus.Busy, bus.Idle);
    end
    clr = 1'b0;
    clear_model();
    tick();
    ia = 0;
    for (int c = 0; c < 5; c++) begin
      bus.A_Valid = 1'b1; bus.A_Wr = 5'(ia + 1);  bus.A_D = 32'h0000_0100 + ia;
      bus.B_Valid = 1'b1; bus.B_Wr = 5'(ia + 20); bus.B_D = 32'h8000_0100 + ia;
      tick();
      if (a_acc) ia++;
    end
    #2 clr = 1'b1;
    #1;
    total++;
    if ({bus.We, bus.Busy, bus.Idle} !== {1'b0, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid: got we=%b busy=%h idle=%b want 0 0 1", bus.We, bus.Busy, bus.Idle);
    end
    idle_inputs();
    clear_model();
    @(posedge clk); #2;
    clr = 1'b0;
    total++;
    if ({bus.A_Ready, bus.B_Ready} !== 2'b11) begin
      bad++;
      $display("FAIL reset_ready: got %b%b want 11", bus.A_Ready, bus.B_Ready);
    end
    tick();
  endtask

  task automatic test_single();
    drain();
    bus.A_Valid = 1'b1; bus.A_Wr = 5'd5; bus.A_D = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    total++;
    if ({bus.We, bus.Busy[5]} !== 2'b01) begin
      bad++;
      $display("FAIL single_accept: got we=%b busy5=%b want 0 1", bus.We, bus.Busy[5]);
    end
    tick();
    total++;
    if ({bus.We, bus.Wr, bus.D, bus.Busy[5]} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1}) begin
      bad++;
      $display("FAIL single_write: got we=%b wr=%0d d=%h busy5=%b want 1 5 deadbeef 1",
               bus.We, bus.Wr, bus.D, bus.Busy[5]);
    end
    tick();
    total++;
    if ({bus.We, bus.Busy[5]} !== 2'b00) begin
      bad++;
      $display("FAIL single_commit: got we=%b busy5=%b want 0 0", bus.We, bus.Busy[5]);
    end
  endtask

  task automatic test_contention();
    int ia, ib;
    bit a_low, b_low;
    drain();
    grants.delete();
    ia = 0; ib = 0; a_low = 0; b_low = 0;
    for (int c = 0; c < 8; c++) begin
      bus.A_Valid = 1'b1; bus.A_Wr = 5'(ia + 1);  bus.A_D = 32'h0000_1000 + ia;
      bus.B_Valid = 1'b1; bus.B_Wr = 5'(ib + 17); bus.B_D = 32'h8000_2000 + ib;
      tick();
      if (a_acc) ia++;
      if (b_acc) ib++;
      if (!bus.A_Ready) a_low = 1;
      if (!bus.B_Ready) b_low = 1;
    end
    idle_inputs();
    drain();
    total++;
    if ({a_low, b_low} !== 2'b11) begin
      bad++;
      $display("FAIL contention_full: got a_low=%b b_low=%b want 1 1", a_low, b_low);
    end
    for (int k = 1; k < 6; k++) begin
      total++;
      if (grants.size() <= k || grants[k] === grants[k-1]) begin
        bad++;
        $display("FAIL contention_alt: grant %0d got %0d want alternation (n=%0d)", k,
                 (grants.size() > k) ? int'(grants[k]) : -1, grants.size());
      end
    end
  endtask

  task automatic test_same_reg();
    do_reset();
    bus.A_Valid = 1'b1; bus.A_Wr = 5'd9; bus.A_D = 32'd1;
    bus.B_Valid = 1'b1; bus.B_Wr = 5'd9; bus.B_D = 32'd2;
    tick();
    idle_inputs();
    tick();
    total++;
    if ({bus.We, bus.Wr, bus.D} !== {1'b1, 5'd9, 32'd1}) begin
      bad++;
      $display("FAIL same_first: got we=%b wr=%0d d=%0d want 1 9 1", bus.We, bus.Wr, bus.D);
    end
    tick();
    total++;
    if ({bus.We, bus.D, bus.Busy[9]} !== {1'b1, 32'd2, 1'b1}) begin
      bad++;
      $display("FAIL same_second: got we=%b d=%0d busy9=%b want 1 2 1", bus.We, bus.D, bus.Busy[9]);
    end
    tick();
    total++;
    if ({bus.We, bus.Busy[9]} !== 2'b00) begin
      bad++;
      $display("FAIL same_done: got we=%b busy9=%b want 0 0", bus.We, bus.Busy[9]);
    end
  endtask

  task automatic test_r0();
    drain();
    bus.A_Valid = 1'b1; bus.A_Wr = 5'd0; bus.A_D = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if ({bus.A_Ready, bus.We, bus.Busy, bus.Idle} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
        bad++;
        $display("FAIL r0: got rdy=%b we=%b busy=%h idle=%b want 1 0 0 1",
                 bus.A_Ready, bus.We, bus.Busy, bus.Idle);
      end
    end
    idle_inputs();
  endtask

  task automatic test_full_pop();
    int ia, ib, na;
    drain();
    grants.delete();
    ia = 0; ib = 0;
    for (int c = 0; c < 12; c++) begin
      bus.A_Valid = 1'b1; bus.A_Wr = 5'((ia % 30) + 1); bus.A_D = 32'h0000_3000 + ia;
      bus.B_Valid = 1'b1; bus.B_Wr = 5'((ib % 30) + 1); bus.B_D = 32'h8000_3000 + ib;
      tick();
      if (a_acc) ia++;
      if (b_acc) ib++;
    end
    idle_inputs();
    drain();
    na = 0;
    foreach (grants[k]) if (!grants[k]) na++;
    total++;
    if (na != ia) begin
      bad++;
      $display("FAIL full_pop_count: got %0d A writes want %0d", na, ia);
    end
  endtask

  task automatic test_random();
    drain();
    for (int c = 0; c < 400; c++) begin
      if (!bus.A_Valid || a_acc) begin
        bus.A_Valid = 1'($urandom_range(0, 1));
        bus.A_Wr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.A_D     = {1'b0, 31'($urandom)};
      end
      if (!bus.B_Valid || b_acc) begin
        bus.B_Valid = 1'($urandom_range(0, 1));
        bus.B_Wr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.B_D     = {1'b1, 31'($urandom)};
      end
      tick();
    end
    idle_inputs();
    drain();
  endtask

  initial begin
    clear_model();
    test_reset();
    test_single();
    test_contention();
    test_same_reg();
    test_r0();
    test_full_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
